// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes rx, centres on the start bit and samples each
// bit mid-period, emitting one-cycle data_valid / framing_error strobes.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic       framing_error,
  output logic [2:0] debug_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_sync;
  logic [CNT_W-1:0] count;
  logic [2:0]       bit_index;
  logic [7:0]       shift;

  // Idle-high reset keeps a quiet line from looking like a start bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= '0;
      bit_index     <= '0;
      shift         <= '0;
      received_data <= 8'h00;
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid    <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        IDLE: begin
          count     <= '0;
          bit_index <= '0;
          if (!rx_sync) state <= START;
        end
        // A start bit that has gone high again by its midpoint is a glitch.
        START: begin
          if (count == HALF) begin
            count <= '0;
            if (!rx_sync) begin
              state     <= DATA;
              bit_index <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DATA: begin
          if (count == LAST) begin
            count <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_index == 3'd7) state <= STOP;
            else bit_index <= bit_index + 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        STOP: begin
          if (count == LAST) begin
            count <= '0;
            if (rx_sync) begin
              received_data <= shift;
              data_valid    <= 1'b1;
            end else begin
              framing_error <= 1'b1;
            end
            state <= CLEANUP;
          end else begin
            count <= count + 1'b1;
          end
        end
        CLEANUP: state <= IDLE;
        default: begin
          state     <= IDLE;
          count     <= '0;
          bit_index <= '0;
        end
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frames plus hand-written
// sequences for reset, glitch rejection, mid-frame reset and all byte values.
module tb_uart_receiver;

  localparam int C = 16;
  // Stop-bit sample edge after start-bit capture: 3 + H + 9*C with H = 7.
  localparam int EVENT_OFFSET = 3 + (C / 2 - 1) + 9 * C;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] received_data;
  logic       data_valid;
  logic       framing_error;
  logic [2:0] debug_state;

  int applied = 0;
  int miscompares = 0;
  int cycle_count = 0;
  int frame_start = 0;
  int last_event_cycle = 0;
  int dv_pulses = 0, dv_high = 0, fe_pulses = 0, fe_high = 0;
  logic dv_prev = 1'b0, fe_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         idle_after;
    logic       exp_valid;
    logic       exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  uart_receiver #(.CLKS_PER_BIT(C)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .received_data (received_data),
    .data_valid    (data_valid),
    .framing_error (framing_error),
    .debug_state   (debug_state)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cycle_count = cycle_count + 1;

  // Strobes are counted both as rising edges and as high cycles so a stretched
  // pulse shows up as a count difference.
  always @(negedge clock) begin
    if (data_valid) begin
      dv_high = dv_high + 1;
      if (!dv_prev) begin
        dv_pulses = dv_pulses + 1;
        last_event_cycle = cycle_count;
      end
    end
    if (framing_error) begin
      fe_high = fe_high + 1;
      if (!fe_prev) begin
        fe_pulses = fe_pulses + 1;
        last_event_cycle = cycle_count;
      end
    end
    dv_prev = data_valid;
    fe_prev = framing_error;
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    applied = applied + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Entered on a negedge; leaves rx at the stop level so frames chain directly.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
    frame_start = cycle_count + 1;
    rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (C) @(negedge clock);
    end
    rx = stop_bit;
    repeat (C) @(negedge clock);
  endtask

  initial begin
    int base_dv, base_dvh, base_fe, base_feh;
    logic saw_start, saw_other;

    vecs[0] = '{8'hFF, 1'b1, 0,  1'b1, 1'b0, 8'hFF};
    vecs[1] = '{8'h20, 1'b1, 0,  1'b1, 1'b0, 8'h20};
    vecs[2] = '{8'h3C, 1'b1, 0,  1'b1, 1'b0, 8'h3C};
    vecs[3] = '{8'hC3, 1'b0, 20, 1'b0, 1'b1, 8'h3C};
    vecs[4] = '{8'h81, 1'b1, 0,  1'b1, 1'b0, 8'h81};
    vecs[5] = '{8'h00, 1'b1, 10, 1'b1, 1'b0, 8'h00};

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    check_output("reset_outputs",
                 32'({received_data, data_valid, framing_error, debug_state}), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      check_output("idle_quiet",
                   32'({received_data, data_valid, framing_error, debug_state}), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      base_dv = dv_pulses;  base_dvh = dv_high;
      base_fe = fe_pulses;  base_feh = fe_high;
      apply_stimulus(vecs[i].data, vecs[i].stop_bit);
      check_output("vec_valid_pulses", 32'(dv_pulses - base_dv), 32'(vecs[i].exp_valid));
      check_output("vec_valid_width", 32'(dv_high - base_dvh), 32'(vecs[i].exp_valid));
      check_output("vec_ferr_pulses", 32'(fe_pulses - base_fe), 32'(vecs[i].exp_ferr));
      check_output("vec_ferr_width", 32'(fe_high - base_feh), 32'(vecs[i].exp_ferr));
      check_output("vec_data", 32'(received_data), 32'(vecs[i].exp_data));
      check_output("vec_event_cycle", 32'(last_event_cycle - frame_start), 32'(EVENT_OFFSET));
      if (vecs[i].idle_after > 0) begin
        rx = 1'b1;
        repeat (vecs[i].idle_after) @(negedge clock);
      end
    end

    // Glitch: four low cycles must reach START and fall back without output.
    rx = 1'b1;
    repeat (10) @(negedge clock);
    base_dv = dv_pulses;
    base_fe = fe_pulses;
    saw_start = 1'b0;
    saw_other = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clock);
      if (debug_state == 3'd1) saw_start = 1'b1;
      else if (debug_state != 3'd0) saw_other = 1'b1;
    end
    check_output("glitch_saw_start", 32'(saw_start), 32'd1);
    check_output("glitch_no_data_state", 32'(saw_other), 32'd0);
    check_output("glitch_back_idle", 32'(debug_state), 32'd0);
    check_output("glitch_no_valid", 32'(dv_pulses - base_dv), 32'd0);
    check_output("glitch_no_ferr", 32'(fe_pulses - base_fe), 32'd0);
    base_dv = dv_pulses;
    apply_stimulus(8'hA5, 1'b1);
    check_output("after_glitch_valid", 32'(dv_pulses - base_dv), 32'd1);
    check_output("after_glitch_data", 32'(received_data), 32'hA5);

    // Reset asserted between clock edges in the middle of data bit 4.
    rx = 1'b1;
    repeat (10) @(negedge clock);
    rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : 1'b1;
      repeat (C) @(negedge clock);
    end
    rx = 1'b1;
    repeat (C / 2) @(negedge clock);
    check_output("midframe_in_data", 32'(debug_state), 32'd2);
    #3 reset_n = 1'b0;
    #2 check_output("midframe_async_clear",
                    32'({received_data, data_valid, framing_error, debug_state}), 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    base_dv = dv_pulses;
    apply_stimulus(8'h0F, 1'b1);
    check_output("after_reset_valid", 32'(dv_pulses - base_dv), 32'd1);
    check_output("after_reset_data", 32'(received_data), 32'h0F);

    rx = 1'b1;
    repeat (10) @(negedge clock);
    base_fe = fe_pulses;
    for (int v = 0; v < 256; v++) begin
      base_dv = dv_pulses;
      base_dvh = dv_high;
      apply_stimulus(8'(v), 1'b1);
      check_output("sweep_valid", 32'(dv_pulses - base_dv), 32'd1);
      check_output("sweep_width", 32'(dv_high - base_dvh), 32'd1);
      check_output("sweep_data", 32'(received_data), 32'(v));
    end
    rx = 1'b1;
    repeat (10) @(negedge clock);
    check_output("sweep_no_ferr", 32'(fe_pulses - base_fe), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
